// File: rtl/offnariscv_pkg.sv
// Shared offnariscv pipeline types plus the pure branch-resolution function
// that is reused by ID / branch-predictor checks.
package offnariscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      BRU_JAL,
      BRU_JALR,
      BRU_BEQ,
      BRU_BNE,
      BRU_BLT,
      BRU_BGE,
      BRU_BLTU,
      BRU_BGEU
   } bru_cmd_e;

   typedef struct packed {
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] offset;
      logic [XLEN-1:0] this_pc;
      bru_cmd_e        cmd;
   } rfbru_tdata_t;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] new_pc;
      logic            taken;
   } bruwb_tdata_t;

   typedef enum logic [1:0] {StEmpty, StFull1, StFull2} skid_state_e;

   function automatic bruwb_tdata_t bru_resolve(rfbru_tdata_t in);
      bruwb_tdata_t    out;
      logic [XLEN-1:0] seq;
      logic [XLEN-1:0] tgt;
      logic            lt_s;
      logic            lt_u;
      seq  = in.this_pc + XLEN'(4);
      tgt  = in.this_pc + in.offset;
      lt_s = $signed(in.op1) < $signed(in.op2);
      lt_u = in.op1 < in.op2;
      out  = '0;
      unique case (in.cmd)
         BRU_JAL:  out.taken = 1'b1;
         BRU_JALR: out.taken = 1'b1;
         BRU_BEQ:  out.taken = (in.op1 == in.op2);
         BRU_BNE:  out.taken = (in.op1 != in.op2);
         BRU_BLT:  out.taken = lt_s;
         BRU_BGE:  out.taken = !lt_s;
         BRU_BLTU: out.taken = lt_u;
         BRU_BGEU: out.taken = !lt_u;
      endcase
      if (in.cmd == BRU_JAL || in.cmd == BRU_JALR) begin
         out.result = seq;
      end
      if (in.cmd == BRU_JALR) begin
         // JALR clears bit 0 only; bit 1 misalignment is left for WB/trap logic
         out.new_pc = (in.op1 + in.offset) & ~XLEN'(1);
      end else begin
         out.new_pc = out.taken ? tgt : seq;
      end
      return out;
   endfunction

endpackage

// File: rtl/offnariscv_bru_if.sv
// RF->BRU and BRU->WB AXI-Stream links; master = surrounding pipeline, slave = BRU.
interface offnariscv_bru_if;
   import offnariscv_pkg::*;

   rfbru_tdata_t s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   bruwb_tdata_t m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready;

   modport master (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid
   );

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid
   );
endinterface

// File: rtl/offnariscv_skid_buf.sv
// Generic two-entry skid buffer with flush; s_ready derives from state only,
// never from m_ready.
module offnariscv_skid_buf
   import offnariscv_pkg::*;
#(
   parameter type T = logic
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  T     s_data,
   input  logic s_valid,
   output logic s_ready,
   output T     m_data,
   output logic m_valid,
   input  logic m_ready
);

   skid_state_e state_q, state_d;
   T            out_q, skid_q;
   logic        accept;
   logic        load_out_in, load_out_skid, load_skid;

   assign accept = s_valid && s_ready;
   assign m_data = out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: if (accept) state_d = StFull1;
            StFull1: begin
               if (accept && !m_ready) state_d = StFull2;
               else if (!accept && m_ready) state_d = StEmpty;
            end
            StFull2: if (m_ready) state_d = StFull1;
            default: state_d = StEmpty;
         endcase
      end
   end

   always_comb begin
      // Flush forces ready so an offered beat is swallowed in the squash cycle
      s_ready       = !rst && (flush || state_q != StFull2);
      m_valid       = (state_q != StEmpty);
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (!flush) begin
         unique case (state_q)
            StEmpty: load_out_in = s_valid;
            StFull1: begin
               load_out_in = s_valid && m_ready;
               load_skid   = s_valid && !m_ready;
            end
            StFull2: load_out_skid = m_ready;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_in) begin
            out_q <= s_data;
         end else if (load_out_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= s_data;
         end
      end
   end

endmodule

// File: rtl/offnariscv_bru.sv
// Branch/jump execution unit: resolves on the input side, then buffers the
// computed result toward WB (skid buffer or single register).
module offnariscv_bru
   import offnariscv_pkg::*;
#(
   parameter int unsigned SKID = 1
) (
   input logic             clk,
   input logic             rst,
   input logic             flush,
   offnariscv_bru_if.slave axis
);

   bruwb_tdata_t res;

   assign res = bru_resolve(axis.s_axis_tdata);

   if (SKID != 0) begin : g_skid
      offnariscv_skid_buf #(
         .T (bruwb_tdata_t)
      ) u_skid_buf (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .s_data  (res),
         .s_valid (axis.s_axis_tvalid),
         .s_ready (axis.s_axis_tready),
         .m_data  (axis.m_axis_tdata),
         .m_valid (axis.m_axis_tvalid),
         .m_ready (axis.m_axis_tready)
      );
   end else begin : g_reg
      bruwb_tdata_t out_q;
      logic         valid_q;
      logic         ready;

      assign ready              = !rst && (flush || !valid_q || axis.m_axis_tready);
      assign axis.s_axis_tready = ready;
      assign axis.m_axis_tdata  = out_q;
      assign axis.m_axis_tvalid = valid_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
         end else if (flush) begin
            valid_q <= 1'b0;
         end else if (ready && axis.s_axis_tvalid) begin
            valid_q <= 1'b1;
            out_q   <= res;
         end else if (axis.m_axis_tready) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_offnariscv_bru.sv
// Bench for offnariscv_bru: directed vector table, backpressure/flush/reset
// sequences and a randomized stream scored against a behavioural model.
module tb_offnariscv_bru;
   import offnariscv_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;
   bit   mon_en = 1'b0;

   bruwb_tdata_t sb[$];
   bit           held_v = 1'b0;
   bruwb_tdata_t held_d;

   always #5 clk = ~clk;

   offnariscv_bru_if bus ();

   offnariscv_bru #(
      .SKID (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .axis  (bus.slave)
   );

   typedef struct {
      bru_cmd_e    cmd;
      logic [31:0] op1, op2, off, pc;
      logic [31:0] res, npc;
      logic        tk;
   } vec_t;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model straight from the ISA rules, using wide integer arithmetic
   function automatic bruwb_tdata_t ref_model(rfbru_tdata_t b);
      bruwb_tdata_t r;
      longint       s1, s2;
      longint       u1, u2;
      longint       link, jump;
      bit           cond;
      s1   = longint'($signed(b.op1));
      s2   = longint'($signed(b.op2));
      u1   = longint'({32'b0, b.op1});
      u2   = longint'({32'b0, b.op2});
      link = (longint'(b.this_pc) + 4) % 64'h1_0000_0000;
      jump = (longint'(b.this_pc) + longint'(b.offset)) % 64'h1_0000_0000;
      cond = 1'b0;
      r    = '0;
      case (b.cmd)
         BRU_JAL: begin
            r.result = 32'(link); r.new_pc = 32'(jump); r.taken = 1'b1;
         end
         BRU_JALR: begin
            r.result = 32'(link);
            r.taken  = 1'b1;
            r.new_pc = 32'(((longint'(b.op1) + longint'(b.offset)) % 64'h1_0000_0000) / 2 * 2);
         end
         default: begin
            case (b.cmd)
               BRU_BEQ:  cond = (u1 == u2);
               BRU_BNE:  cond = (u1 != u2);
               BRU_BLT:  cond = (s1 < s2);
               BRU_BGE:  cond = (s1 >= s2);
               BRU_BLTU: cond = (u1 < u2);
               default:  cond = (u1 >= u2);
            endcase
            r.taken  = cond;
            r.new_pc = cond ? 32'(jump) : 32'(link);
         end
      endcase
      return r;
   endfunction

   function automatic rfbru_tdata_t rand_beat();
      rfbru_tdata_t b;
      b.cmd     = bru_cmd_e'(3'($urandom_range(0, 7)));
      b.op1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b.op2     = ($urandom_range(0, 3) == 0) ? b.op1 : $urandom;
      b.offset  = $urandom;
      b.this_pc = $urandom;
      return b;
   endfunction

   // Scoreboard monitor, sampling away from the active edge
   always @(negedge clk) begin
      if (mon_en) begin
         if (held_v) begin
            check("stall_valid_stable", 96'(bus.m_axis_tvalid), 96'(1));
            check("stall_data_stable", 96'(bus.m_axis_tdata), 96'(held_d));
         end
         if (rst || flush) begin
            sb.delete();
         end else begin
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
               pops++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected none", bus.m_axis_tdata);
               end else if (bus.m_axis_tdata !== sb[0]) begin
                  errors++;
                  $display("FAIL stream_order: got %h expected %h", bus.m_axis_tdata, sb[0]);
                  void'(sb.pop_front());
               end else begin
                  void'(sb.pop_front());
               end
            end
            if (bus.s_axis_tvalid && bus.s_axis_tready) sb.push_back(ref_model(bus.s_axis_tdata));
         end
         held_v = bus.m_axis_tvalid && !bus.m_axis_tready && !rst && !flush;
         held_d = bus.m_axis_tdata;
      end else begin
         held_v = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[8];
      bruwb_tdata_t e;
      rfbru_tdata_t b;
      rfbru_tdata_t bq[4];
      int           idx;
      int           base;

      vecs[0] = '{BRU_BEQ,  32'd5,        32'd5, 32'h20, 32'h100,      32'h0,   32'h120, 1'b1};
      vecs[1] = '{BRU_BLT,  32'hFFFFFFFF, 32'd1, 32'h20, 32'h100,      32'h0,   32'h120, 1'b1};
      vecs[2] = '{BRU_BLTU, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100,      32'h0,   32'h104, 1'b0};
      vecs[3] = '{BRU_JALR, 32'h1003,     32'd0, 32'h4,  32'h200,      32'h204, 32'h1006, 1'b1};
      vecs[4] = '{BRU_JAL,  32'd0,        32'd0, 32'h8,  32'hFFFFFFFC, 32'h0,   32'h4,   1'b1};
      vecs[5] = '{BRU_BGE,  32'hFFFFFFFF, 32'd1, 32'h40, 32'h300,      32'h0,   32'h304, 1'b0};
      vecs[6] = '{BRU_BGEU, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h300,      32'h0,   32'h340, 1'b1};
      vecs[7] = '{BRU_BNE,  32'd3,        32'd3, 32'h40, 32'h300,      32'h0,   32'h304, 1'b0};

      rst   = 1'b1;
      flush = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.m_axis_tready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_m_valid", 96'(bus.m_axis_tvalid), 96'(0));
      check("rst_m_data", 96'(bus.m_axis_tdata), 96'(0));
      check("rst_s_ready", 96'(bus.s_axis_tready), 96'(0));
      rst = 1'b0;
      tick();
      check("post_rst_s_ready", 96'(bus.s_axis_tready), 96'(1));

      // Directed vectors, one beat at a time with 1-cycle latency
      bus.m_axis_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b.cmd = vecs[i].cmd; b.op1 = vecs[i].op1; b.op2 = vecs[i].op2;
         b.offset = vecs[i].off; b.this_pc = vecs[i].pc;
         e.result = vecs[i].res; e.new_pc = vecs[i].npc; e.taken = vecs[i].tk;
         bus.s_axis_tdata  = b;
         bus.s_axis_tvalid = 1'b1;
         tick();
         bus.s_axis_tvalid = 1'b0;
         check($sformatf("vec%0d_valid", i), 96'(bus.m_axis_tvalid), 96'(1));
         check($sformatf("vec%0d_data", i), 96'(bus.m_axis_tdata), 96'(e));
         tick();
         check($sformatf("vec%0d_drained", i), 96'(bus.m_axis_tvalid), 96'(0));
      end

      mon_en = 1'b1;

      // Backpressure: four beats, WB stalled for three cycles
      for (int k = 0; k < 4; k++) bq[k] = rand_beat();
      idx  = 0;
      base = pops;
      for (int c = 0; c < 30 && (idx < 4 || sb.size() != 0 || c < 2); c++) begin
         bus.m_axis_tready = (c >= 3);
         bus.s_axis_tvalid = (idx < 4);
         if (idx < 4) bus.s_axis_tdata = bq[idx];
         @(negedge clk);
         if (c == 2) check("bp_ready_low_full2", 96'(bus.s_axis_tready), 96'(0));
         if (bus.s_axis_tvalid && bus.s_axis_tready) idx++;
         tick();
      end
      bus.s_axis_tvalid = 1'b0;
      check("bp_all_accepted", 96'(idx), 96'(4));
      check("bp_all_emerged", 96'(pops - base), 96'(4));

      // Flush while two beats are held and a third is offered
      bus.m_axis_tready = 1'b0;
      bus.s_axis_tdata  = rand_beat();
      bus.s_axis_tvalid = 1'b1;
      tick();
      bus.s_axis_tdata  = rand_beat();
      tick();
      bus.s_axis_tdata  = rand_beat();
      flush = 1'b1;
      @(negedge clk);
      check("flush_s_ready", 96'(bus.s_axis_tready), 96'(1));
      tick();
      flush = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      check("flush_m_valid", 96'(bus.m_axis_tvalid), 96'(0));
      bus.m_axis_tready = 1'b1;
      tick();
      tick();
      check("flush_no_ghost", 96'(bus.m_axis_tvalid), 96'(0));
      b = rand_beat();
      bus.s_axis_tdata  = b;
      bus.s_axis_tvalid = 1'b1;
      tick();
      bus.s_axis_tvalid = 1'b0;
      check("post_flush_valid", 96'(bus.m_axis_tvalid), 96'(1));
      check("post_flush_data", 96'(bus.m_axis_tdata), 96'(ref_model(b)));
      tick();

      // Reset in FULL2
      bus.m_axis_tready = 1'b0;
      bus.s_axis_tdata  = rand_beat();
      bus.s_axis_tvalid = 1'b1;
      tick();
      bus.s_axis_tdata  = rand_beat();
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("rst_full2_s_ready", 96'(bus.s_axis_tready), 96'(0));
      tick();
      check("rst_full2_m_valid", 96'(bus.m_axis_tvalid), 96'(0));
      check("rst_full2_s_ready2", 96'(bus.s_axis_tready), 96'(0));
      tick();
      rst = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      tick();
      check("rst_release_s_ready", 96'(bus.s_axis_tready), 96'(1));
      check("rst_release_m_valid", 96'(bus.m_axis_tvalid), 96'(0));

      // Randomized stream with random backpressure and occasional flush
      for (int c = 0; c < 600; c++) begin
         bus.s_axis_tvalid = ($urandom_range(0, 9) < 7);
         bus.s_axis_tdata  = rand_beat();
         bus.m_axis_tready = ($urandom_range(0, 9) < 6);
         flush             = ($urandom_range(0, 49) == 0);
         tick();
      end
      flush = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b1;
      for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
      tick();
      check("random_drain_empty", 96'(sb.size()), 96'(0));
      check("random_idle_valid", 96'(bus.m_axis_tvalid), 96'(0));

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
